// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage pipeline registers
// (PC, IF/ID, ID/EXE, EXE/MEM). Resolves load-use hazards, taken-branch
// redirects, MEM-stage exceptions and multi-cycle divide stalls.
// Outputs are combinational from the registered FSM state plus the
// same-cycle hazard inputs.
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   defined   : 32-bit stall-cycle and flush-event counters are built
//   undefined : PERF_StallCnt / PERF_FlushCnt are tied to zero
//
// Parameters
//   DIV_CYCLES  EXE occupancy of DIV/DIVU in cycles incl. release cycle (2..63)
//   CNT_W       divide down-counter width, 2**CNT_W > DIV_CYCLES
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ID_rs, ID_rt      source registers of the instruction in ID
//   EXE_ReadMem       EXE instruction is a load
//   EXE_RFWr          EXE instruction writes a GPR
//   EXE_Dst           EXE destination register
//   EXE_BranchTaken   taken branch/jump resolved in EXE
//   EXE_IsDiv         EXE instruction is DIV/DIVU
//   MEM_ExceptValid   exception in MEM, handler redirect valid
//   IF_PCWr, IF_IDWr  PC and IF/ID write enables
//   IFID_Flush, IDEXE_Flush, EXEMEM_Flush  stage-register clears
//   EXE_Hold          ID/EXE hold during a divide
//   DIV_Start         one-cycle divider start pulse
//   DIV_Busy          divider occupied (S_BUSY)
//   PERF_StallCnt     stall-cycle counter
//   PERF_FlushCnt     flush-event counter
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic        EXE_ReadMem,
   input  logic        EXE_RFWr,
   input  logic [4:0]  EXE_Dst,
   input  logic        EXE_BranchTaken,
   input  logic        EXE_IsDiv,
   input  logic        MEM_ExceptValid,
   output logic        IF_PCWr,
   output logic        IF_IDWr,
   output logic        IFID_Flush,
   output logic        IDEXE_Flush,
   output logic        EXE_Hold,
   output logic        EXEMEM_Flush,
   output logic        DIV_Start,
   output logic        DIV_Busy,
   output logic [31:0] PERF_StallCnt,
   output logic [31:0] PERF_FlushCnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             load_use;

   // Register 0 is hard-wired to zero, so it can never carry a hazard.
   always_comb begin
      load_use = EXE_ReadMem & EXE_RFWr & (EXE_Dst != 5'd0) &
                 ((EXE_Dst == ID_rs) | (EXE_Dst == ID_rt));
   end

   always_comb begin
      IF_PCWr      = 1'b1;
      IF_IDWr      = 1'b1;
      IFID_Flush   = 1'b0;
      IDEXE_Flush  = 1'b0;
      EXE_Hold     = 1'b0;
      EXEMEM_Flush = 1'b0;
      DIV_Start    = 1'b0;
      DIV_Busy     = (state == S_BUSY);
      state_nxt    = state;
      cnt_nxt      = cnt;

      if (rst) begin
         // Freeze fetch and bubble every stage register while in reset.
         IF_PCWr      = 1'b0;
         IF_IDWr      = 1'b0;
         IFID_Flush   = 1'b1;
         IDEXE_Flush  = 1'b1;
         EXEMEM_Flush = 1'b1;
         DIV_Busy     = 1'b0;
         state_nxt    = S_IDLE;
         cnt_nxt      = '0;
      end else if (MEM_ExceptValid) begin
         // Exception wins over everything, including an in-flight divide;
         // PC takes the handler address.
         IF_IDWr      = 1'b0;
         IFID_Flush   = 1'b1;
         IDEXE_Flush  = 1'b1;
         EXEMEM_Flush = 1'b1;
         state_nxt    = S_IDLE;
         cnt_nxt      = '0;
      end else if (state == S_BUSY) begin
         IF_PCWr      = 1'b0;
         IF_IDWr      = 1'b0;
         EXE_Hold     = 1'b1;
         EXEMEM_Flush = 1'b1;
         cnt_nxt      = cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            state_nxt = S_DONE;
         end
      end else if ((state == S_IDLE) && EXE_IsDiv) begin
         // Start cycle counts as the first of DIV_CYCLES; the S_DONE
         // release cycle is the last, leaving DIV_CYCLES-2 busy cycles.
         IF_PCWr      = 1'b0;
         IF_IDWr      = 1'b0;
         EXE_Hold     = 1'b1;
         EXEMEM_Flush = 1'b1;
         DIV_Start    = 1'b1;
         if (DIV_CYCLES == 2) begin
            state_nxt = S_DONE;
         end else begin
            state_nxt = S_BUSY;
            cnt_nxt   = CNT_W'(DIV_CYCLES - 2);
         end
      end else begin
         // S_IDLE without a divide, or S_DONE (EXE_IsDiv still asserted by
         // the finishing divide is deliberately ignored here).
         state_nxt = S_IDLE;
         if (EXE_BranchTaken) begin
            // Delay slot in ID proceeds, only the wrong-path fetch is killed.
            IFID_Flush = 1'b1;
         end else if (load_use) begin
            IF_PCWr     = 1'b0;
            IF_IDWr     = 1'b0;
            IDEXE_Flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= 32'h0;
         flush_cnt <= 32'h0;
      end else begin
         if (!IF_PCWr) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (IFID_Flush | IDEXE_Flush | EXEMEM_Flush) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end

   assign PERF_StallCnt = stall_cnt;
   assign PERF_FlushCnt = flush_cnt;
`else
   assign PERF_StallCnt = 32'h0;
   assign PERF_FlushCnt = 32'h0;
`endif

endmodule
